serial_ones_rx: RTL and testbench
=================================

Name: serial_ones_rx

Overview:
- Serial-input counterpart of the combinational parallel ones-counter (8-bit word in, 4-bit ones count out).
- Receives a word one bit per clock (LSB first) under a start/valid handshake, reassembles it, and counts its 1 bits on the fly.
- Presents the word and its ones count with a one-cycle done pulse.
- Sits between a bit-serial link and consumers of the parallel ones-count result.

Parameters:
- WIDTH, 8, number of data bits per frame.
- CW, 4, width of the ones count; must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame start strobe; sampled every cycle.
- din  input  1  serial data bit.
- din_valid  input  1  din carries a valid data bit this cycle.
- word  output  WIDTH  last completed frame, bit 0 = first bit received.
- ones  output  CW  number of 1 bits in word.
- done  output  1  one-cycle pulse: word/ones just updated.
- busy  output  1  high while a frame is in progress (SHIFT state).
- err  output  1  one-cycle pulse: frame aborted by start mid-frame.

Behaviour:
- Reset (reset=1 at a clock edge): state=IDLE; word=0, ones=0, done=0, busy=0, err=0; bit counter, shift register and running count cleared. Reset overrides all other inputs, including mid-frame.
- State IDLE: din/din_valid ignored. start=1 -> SHIFT; bit counter=0, running count=0.
- State SHIFT, busy=1. On each cycle with din_valid=1 and start=0:
  - shift register bit[bitcnt] <= din;
  - running count += din;
  - bitcnt += 1.
- din_valid=0 in SHIFT: hold state; no timeout.
- Frame completion: when the WIDTH-th valid bit is sampled (bitcnt == WIDTH-1 and din_valid=1), the same edge:
  - loads word with the full assembled value (including that bit);
  - loads ones with the final count (including that bit);
  - moves to DONE.
- State DONE, lasting exactly one cycle:
  - done=1, busy=0.
  - Next state is SHIFT if start=1 (new frame; counters cleared), else IDLE.
  - A din_valid in the DONE cycle is ignored; the new frame's first bit must arrive after the start cycle.
- start=1 while in SHIFT: current frame discarded; word/ones unchanged; err=1 in the next cycle; state stays SHIFT with counters cleared. A din_valid in that same cycle is ignored.
- start and din_valid both high in IDLE: start is taken, the bit is ignored.
- Latency: done rises 1 cycle after the edge sampling the last bit; the minimum frame is 1 start cycle + WIDTH valid cycles.
- Output retention: word/ones hold the last completed frame until the next completion or reset.
- Arithmetic:
  - Running count is CW bits, unsigned.
  - The maximum value is WIDTH (8 for the defaults), so it never wraps.
  - ones equals the popcount of word, matching the combinational counter for the same 8-bit value.

Optional Feature:
- Macro: SERIAL_ONES_RX_PARITY_EN.
- Defined:
  - Each frame carries one extra even-parity bit after the WIDTH data bits (WIDTH+1 valid bits per frame).
  - Adds output parity_err (1 bit), updated at completion together with word/ones.
  - parity_err=1 when (popcount of the data bits + parity bit) is odd.
  - parity_err resets to 0.
  - The parity bit is not counted in ones and not stored in word.
- Undefined: frames are exactly WIDTH bits; no parity_err port exists.

Test Plan:
- Reset then start, then 8 valid bits 1,0,1,1,0,0,0,1 (LSB first) -> done pulse 1 cycle after the 8th bit; word=8'b10001101, ones=4'd4; busy low in the done cycle.
- Frame 8'hFF, then frame 8'h00 with din_valid gaps of 3 cycles between bits -> ones=8 then ones=0; word/ones hold 8'hFF/8 until the second done pulse.
- Start, 5 bits, then start again, then 8 bits of 8'h0F -> err=1 one cycle after the second start; no done for the aborted frame; final word=8'h0F, ones=4.
- start asserted in the DONE cycle, followed by 8 bits of 8'hA5 -> back-to-back frames with no IDLE cycle; second done reports word=8'hA5, ones=4.
- Assert reset after 6 bits of a frame -> word=0, ones=0, busy=0; later start + 8'h01 -> word=8'h01, ones=1.
- With SERIAL_ONES_RX_PARITY_EN defined:
  - 8'h07 + parity bit 1 -> parity_err=0, ones=3.
  - 8'h07 + parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/serial_ones_rx.sv
// Bit-serial word receiver: reassembles an LSB-first frame and counts its 1 bits on the fly.
// Optional even-parity trailer bit enabled by defining SERIAL_ONES_RX_PARITY_EN.
module serial_ones_rx #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    ones,
  output logic             done,
  output logic             busy,
`ifdef SERIAL_ONES_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             err
);

  localparam int BW = $clog2(WIDTH + 2);
`ifdef SERIAL_ONES_RX_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [BW-1:0]    bitcnt_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;

  logic             data_bit_s;
  logic             last_s;
  logic [WIDTH-1:0] assembled_s;
  logic [CW-1:0]    cnt_next_s;

`ifdef SERIAL_ONES_RX_PARITY_EN
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  // Next shift-register image and running count for the bit on din this cycle
  always_comb begin
    data_bit_s = din;
`ifdef SERIAL_ONES_RX_PARITY_EN
    // The trailing parity bit is neither stored nor counted
    if (bitcnt_r < BW'(WIDTH)) begin
      data_bit_s = din;
    end else begin
      data_bit_s = 1'b0;
    end
`endif
    last_s      = (bitcnt_r == BW'(LAST));
    assembled_s = shreg_r | (WIDTH'(data_bit_s) << bitcnt_r);
    cnt_next_s  = cnt_r + CW'(data_bit_s);
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      bitcnt_r <= '0;
      shreg_r  <= '0;
      cnt_r    <= '0;
      word     <= '0;
      ones     <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef SERIAL_ONES_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= ST_SHIFT;
            busy     <= 1'b1;
            bitcnt_r <= '0;
            shreg_r  <= '0;
            cnt_r    <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (start) begin
            // Restart: drop the partial frame, keep the last completed result
            err      <= 1'b1;
            bitcnt_r <= '0;
            shreg_r  <= '0;
            cnt_r    <= '0;
          end else if (din_valid) begin
            if (last_s) begin
              state_r <= ST_DONE;
              word    <= assembled_s;
              ones    <= cnt_next_s;
              done    <= 1'b1;
              busy    <= 1'b0;
`ifdef SERIAL_ONES_RX_PARITY_EN
              parity_err <= parity_of(shreg_r) ^ din;
`endif
            end else begin
              shreg_r  <= assembled_s;
              cnt_r    <= cnt_next_s;
              bitcnt_r <= bitcnt_r + BW'(1);
            end
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_r  <= ST_SHIFT;
            busy     <= 1'b1;
            bitcnt_r <= '0;
            shreg_r  <= '0;
            cnt_r    <= '0;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ones_rx.sv
// Directed self-checking bench for serial_ones_rx (both default and parity builds).
module tb_serial_ones_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       din;
  logic       din_valid;
  logic [7:0] word;
  logic [3:0] ones;
  logic       done;
  logic       busy;
  logic       err;
`ifdef SERIAL_ONES_RX_PARITY_EN
  logic       parity_err;
`endif

  int tests = 0;
  int fails = 0;

  serial_ones_rx #(.WIDTH(8), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .word      (word),
    .ones      (ones),
    .done      (done),
    .busy      (busy),
`ifdef SERIAL_ONES_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      if (i != lo) begin
        din_valid = 1'b0;
        repeat (gap) tick();
      end
      din       = w[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  // Data bits followed, in the parity build, by the given parity bit
  task automatic send_word(input logic [7:0] w, input int gap, input logic pbit);
`ifdef SERIAL_ONES_RX_PARITY_EN
    send_bits(w, 0, 7, gap);
    din       = pbit;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = 1'b0;
`else
    send_bits(w, 0, 7, gap);
    if (pbit) begin
      din = 1'b0;
    end
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_word", 32'(word), 32'h00);
    chk("rst_ones", 32'(ones), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err",  32'(err),  32'h0);

    // Frame 1: bits 1,0,1,1,0,0,0,1 LSB first
    do_start();
    chk("f1_busy", 32'(busy), 32'h1);
    send_bits(8'h8D, 0, 6, 0);
    chk("f1_nodone", 32'(done), 32'h0);
    send_bits(8'h8D, 7, 7, 0);
    din_valid = 1'b0;
    chk("f1_done", 32'(done), 32'h1);
    chk("f1_word", 32'(word), 32'h8D);
    chk("f1_ones", 32'(ones), 32'h4);
    chk("f1_busy_done", 32'(busy), 32'h0);
    tick();
    chk("f1_pulse", 32'(done), 32'h0);
    chk("f1_idle_busy", 32'(busy), 32'h0);
    // Without parity the trailing bit is absent
    send_word(8'h00, 0, 1'b0);
    chk("idle_ignores", 32'(word), 32'h8D);

    // 0xFF then 0x00 with 3-cycle gaps
    do_start();
    send_word(8'hFF, 0, 1'b0);
    chk("ff_done", 32'(done), 32'h1);
    chk("ff_ones", 32'(ones), 32'h8);
    chk("ff_word", 32'(word), 32'hFF);
    tick();
    do_start();
    send_bits(8'h00, 0, 3, 3);
    din_valid = 1'b0;
    repeat (3) tick();
    chk("gap_hold_word", 32'(word), 32'hFF);
    chk("gap_hold_ones", 32'(ones), 32'h8);
    chk("gap_busy", 32'(busy), 32'h1);
    send_bits(8'h00, 4, 7, 3);
`ifdef SERIAL_ONES_RX_PARITY_EN
    din = 1'b0; din_valid = 1'b1; tick(); din_valid = 1'b0;
`endif
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_ones", 32'(ones), 32'h0);
    chk("zero_word", 32'(word), 32'h00);
    tick();

    // Abort mid-frame with a second start
    do_start();
    send_bits(8'hFF, 0, 4, 0);
    do_start();
    chk("abort_err", 32'(err), 32'h1);
    chk("abort_nodone", 32'(done), 32'h0);
    chk("abort_busy", 32'(busy), 32'h1);
    chk("abort_word", 32'(word), 32'h00);
    send_bits(8'h0F, 0, 0, 0);
    chk("abort_err_pulse", 32'(err), 32'h0);
    send_bits(8'h0F, 1, 7, 0);
`ifdef SERIAL_ONES_RX_PARITY_EN
    din = 1'b0; din_valid = 1'b1; tick(); din_valid = 1'b0;
`endif
    chk("abort_done", 32'(done), 32'h1);
    chk("abort_final_word", 32'(word), 32'h0F);
    chk("abort_final_ones", 32'(ones), 32'h4);
    tick();

    // Back-to-back frames: start (with a stray valid bit) in the DONE cycle
    do_start();
    send_word(8'h3C, 0, 1'b0);
    chk("b2b_first_done", 32'(done), 32'h1);
    start = 1'b1; din = 1'b1; din_valid = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b0; din = 1'b0;
    chk("b2b_busy", 32'(busy), 32'h1);
    chk("b2b_done_low", 32'(done), 32'h0);
    send_word(8'hA5, 0, 1'b0);
    chk("b2b_done", 32'(done), 32'h1);
    chk("b2b_word", 32'(word), 32'hA5);
    chk("b2b_ones", 32'(ones), 32'h4);
    tick();

    // Reset mid-frame, then start with a simultaneous valid bit in IDLE
    do_start();
    send_bits(8'hFF, 0, 5, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_word", 32'(word), 32'h00);
    chk("mid_rst_ones", 32'(ones), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    start = 1'b1; din = 1'b1; din_valid = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b0; din = 1'b0;
    send_word(8'h01, 0, 1'b1);
    chk("post_rst_done", 32'(done), 32'h1);
    chk("post_rst_word", 32'(word), 32'h01);
    chk("post_rst_ones", 32'(ones), 32'h1);
    tick();

`ifdef SERIAL_ONES_RX_PARITY_EN
    do_start();
    send_word(8'h07, 0, 1'b1);
    chk("par_ok_err", 32'(parity_err), 32'h0);
    chk("par_ok_ones", 32'(ones), 32'h3);
    chk("par_ok_word", 32'(word), 32'h07);
    tick();
    do_start();
    send_word(8'h07, 0, 1'b0);
    chk("par_bad_err", 32'(parity_err), 32'h1);
    chk("par_bad_ones", 32'(ones), 32'h3);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
